register_file_wb: RTL and testbench

//  - Writeback-stage register file of the single-cycle CPU. Consumes the 32-bit

---
 rtl/cpu_regfile_pkg.sv | 11 +
 rtl/regfile_read_port.sv | 40 ++++
 rtl/register_file_wb.sv | 67 ++++++
 tb/tb_register_file_wb.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cpu_regfile_pkg.sv
// Shared register-file types and constants, reused by decode and hazard logic.
package cpu_regfile_pkg;
  localparam int REGF_DATA_W = 32;
  localparam int REGF_ADDR_W = 5;

  typedef logic [REGF_ADDR_W-1:0] reg_idx_t;
  typedef logic [REGF_DATA_W-1:0] word_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_RA   = 5'd31;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port: zero-index masking plus optional
// write-through bypass (enabled by defining REGFILE_WB_BYPASS_EN).
module regfile_read_port
  import cpu_regfile_pkg::*;
#(
  parameter int DATA_W = REGF_DATA_W,
  parameter int ADDR_W = REGF_ADDR_W
) (
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [DATA_W-1:0] i_stored_data,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rd_data
);

  logic w_isZero;
  assign w_isZero = (i_rd_addr == ADDR_W'(REG_ZERO));

`ifdef REGFILE_WB_BYPASS_EN
  logic w_hit;
  assign w_hit = i_wr_valid && (i_rd_addr == i_wr_idx);

  always_comb begin
    o_rd_data = i_stored_data;
    if (w_isZero)   o_rd_data = '0;
    else if (w_hit) o_rd_data = i_wr_data;
  end
`else
  // Write-side inputs only matter for the bypass build.
  logic w_unused;
  assign w_unused = ^{i_wr_valid, i_wr_idx, i_wr_data};

  always_comb begin
    o_rd_data = i_stored_data;
    if (w_isZero) o_rd_data = '0;
  end
`endif

endmodule

// File: rtl/register_file_wb.sv
// Writeback-stage register file: two combinational read ports, one write port,
// JAL return-address override and a wrapping committed-write counter.
// Optional same-cycle write-through bypass: define REGFILE_WB_BYPASS_EN.
module register_file_wb
  import cpu_regfile_pkg::*;
#(
  parameter int DATA_W = REGF_DATA_W,
  parameter int ADDR_W = REGF_ADDR_W,
  parameter int RA_IDX = int'(REG_RA)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_en,
  input  logic              jal,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [15:0]       wr_cnt
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [15:0]       r_wrCnt;
  logic [ADDR_W-1:0] w_wrIdx;
  logic              w_wrValid;
  logic              w_bypassValid;

  assign w_wrIdx   = jal ? ADDR_W'(RA_IDX) : wb_addr;
  assign w_wrValid = wb_en && (w_wrIdx != ADDR_W'(REG_ZERO));
  // Keep bypassed data off the read ports while reset is held.
  assign w_bypassValid = w_wrValid && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_wrCnt <= '0;
    end else if (w_wrValid) begin
      r_regs[w_wrIdx] <= wb_data;
      r_wrCnt         <= r_wrCnt + 16'd1;
    end
  end

  assign wr_cnt = r_wrCnt;

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rsPort (
    .i_rd_addr     (rs_addr),
    .i_stored_data (r_regs[rs_addr]),
    .i_wr_valid    (w_bypassValid),
    .i_wr_idx      (w_wrIdx),
    .i_wr_data     (wb_data),
    .o_rd_data     (rs_data)
  );

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rtPort (
    .i_rd_addr     (rt_addr),
    .i_stored_data (r_regs[rt_addr]),
    .i_wr_valid    (w_bypassValid),
    .i_wr_idx      (w_wrIdx),
    .i_wr_data     (wb_data),
    .o_rd_data     (rt_data)
  );

endmodule

// File: tb/tb_register_file_wb.sv
// Scoreboard bench for register_file_wb: stimulus pushes expected read/counter
// values from an array model; a monitor pops and compares before each edge.
module tb_register_file_wb;
  import cpu_regfile_pkg::*;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYPASS_ON = 1'b1;
`else
  localparam bit BYPASS_ON = 1'b0;
`endif

  typedef struct {
    word_t       rs;
    word_t       rt;
    logic [15:0] cnt;
    string       name;
  } expect_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_en;
  logic        jal;
  reg_idx_t    wb_addr;
  word_t       wb_data;
  reg_idx_t    rs_addr;
  reg_idx_t    rt_addr;
  word_t       rs_data;
  word_t       rt_data;
  logic [15:0] wr_cnt;

  expect_t     sbQueue[$];
  word_t       modelRegs[32];
  int          modelCnt;
  int          nChecks = 0;
  int          nFails  = 0;
  bit          stimDone = 1'b0;

  register_file_wb dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb_en   (wb_en),
    .jal     (jal),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .wr_cnt  (wr_cnt)
  );

  always #5 clk = ~clk;

  // Reference read: index 0 is zero, reset reads zero, otherwise the stored word
  // unless the bypass build sees a valid write to the same index this cycle.
  function automatic word_t modelRead(input logic rstn, input logic we, input logic jl,
                                      input reg_idx_t wa, input word_t wd, input reg_idx_t a);
    int dest;
    dest = jl ? 31 : int'(wa);
    if (!rstn || a == 0) return '0;
    if (BYPASS_ON && we && dest != 0 && int'(a) == dest) return wd;
    return modelRegs[a];
  endfunction

  task automatic applyStimulus(input logic rstn, input logic we, input logic jl,
                               input reg_idx_t wa, input word_t wd,
                               input reg_idx_t ra, input reg_idx_t rb, input string name);
    expect_t e;
    int dest;
    @(negedge clk);
    rst_n = rstn; wb_en = we; jal = jl; wb_addr = wa; wb_data = wd;
    rs_addr = ra; rt_addr = rb;
    if (!rstn) begin
      foreach (modelRegs[i]) modelRegs[i] = '0;
      modelCnt = 0;
    end
    e.rs   = modelRead(rstn, we, jl, wa, wd, ra);
    e.rt   = modelRead(rstn, we, jl, wa, wd, rb);
    e.cnt  = 16'(modelCnt);
    e.name = name;
    sbQueue.push_back(e);
    dest = jl ? 31 : int'(wa);
    if (rstn && we && dest != 0) begin
      modelRegs[dest] = wd;
      modelCnt = (modelCnt + 1) % 65536;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor: outputs settle 2ns after the inputs change, well before the next edge.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbQueue.size() > 0) begin
        e = sbQueue.pop_front();
        checkOutput({e.name, ".rs"},  rs_data, e.rs);
        checkOutput({e.name, ".rt"},  rt_data, e.rt);
        checkOutput({e.name, ".cnt"}, {16'd0, wr_cnt}, {16'd0, e.cnt});
      end
    end
  end

  initial begin
    reg_idx_t ra, rb, wa;
    rst_n = 1'b0; wb_en = 1'b0; jal = 1'b0; wb_addr = '0; wb_data = '0;
    rs_addr = '0; rt_addr = '0;
    foreach (modelRegs[i]) modelRegs[i] = '0;
    modelCnt = 0;

    // Reset held with a write attempt, then every index reads zero after release.
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd4, 32'hFFFF_FFFF, 5'd4, 5'd4, "rst_hold");
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd1, "rst_hold2");
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'(2*i), 5'(2*i+1), "rst_readall");

    applyStimulus(1'b1, 1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2, "wr5");
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, "rd5");

    applyStimulus(1'b1, 1'b1, 1'b1, 5'd7, 32'h0040_0008, 5'd7, 5'd3, "jal");
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd7, "jal_rd");
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd7, 32'h1111_2222, 5'd31, 5'd7, "jal_noen");
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd0, "jal_noen_rd");

    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, "wr0");
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5, "wr0_rd");

    applyStimulus(1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_0001, 5'd0, 5'd9, "pre9");
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd9, 32'h1234_5678, 5'd9, 5'd9, "same9");
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, "after9");

    applyStimulus(1'b1, 1'b1, 1'b0, 5'd3, 32'hA5A5_A5A5, 5'd3, 5'd3, "pre3");
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd9, "rd3");
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd9, "async_rst");
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd31, "post_rst");

    // Randomized traffic with biased addresses to hit zero, RA and port aliasing.
    for (int n = 0; n < 400; n++) begin
      wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom);
      applyStimulus(($urandom_range(0, 99) != 0), 1'($urandom), ($urandom_range(0, 3) == 0),
                    wa, $urandom, ra, rb, "rand");
    end

    stimDone = 1'b1;
    repeat (3) @(negedge clk);
    if (sbQueue.size() != 0) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sbQueue.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
